// File: rtl/array_stats_scan_pkg.sv
// Shared types and width helpers for the array statistics scanner.
package array_stats_pkg;

    typedef enum logic [2:0] {IDLE, READ, EVAL, WRITE, DONE} state_t;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

    // An exact sum of DEPTH entries needs clog2(DEPTH) bits of headroom.
    function automatic int sum_w(input int data_w, input int depth);
        return data_w + $clog2(depth);
    endfunction

endpackage

// File: rtl/array_stats_scan_if.sv
// Host-side bus of the array statistics scanner: load/readback, control and results.
interface array_stats_scan_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    import array_stats_pkg::*;

    localparam int AW = aw_of(DEPTH);
    localparam int SW = sum_w(DATA_W, DEPTH);

    logic              go;
    logic              fold;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] min;
    logic [DATA_W-1:0] max;
    logic [SW-1:0]     sum;
    logic [AW:0]       count_ge;

    modport master (
        output go, fold, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done, min, max, sum, count_ge
    );

    modport slave (
        input  go, fold, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, done, min, max, sum, count_ge
    );

endinterface

// File: rtl/array_stats_scan_regfile.sv
// DEPTH x DATA_W register file: one synchronous read port, one write port, async clear.
module stats_regfile
    import array_stats_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = aw_of(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rdata <= '0;
        end else begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/array_stats_scan.sv
// Array statistics scanner: min/max/sum/count>=THRESH over the register file, optional fold write-back.
// ARRAY_STATS_MAX_EN builds the max tracker; otherwise max is tied to 0.
//
//   state | meaning
//   IDLE  | host owns the register file, waits for go
//   READ  | read issued at idx
//   EVAL  | accumulate read value, decide fold / advance
//   WRITE | store value-THRESH at idx
//   DONE  | scan finished, done pulses on the following cycle
module array_stats_scan
    import array_stats_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int THRESH = 128
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    array_stats_scan_if.slave bus
);

    localparam int AW = aw_of(DEPTH);
    localparam int SW = sum_w(DATA_W, DEPTH);
    localparam int IW = AW + 1;
    localparam logic [DATA_W-1:0] TH = DATA_W'(THRESH);

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic              r_fold;
    logic [DATA_W-1:0] r_v;
    logic [DATA_W-1:0] r_min;
    logic [SW-1:0]     r_sum;
    logic [AW:0]       r_cnt;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] w_rdata;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [AW-1:0]     w_raddr;
    logic              w_ge;
    logic              w_last;

    // Host writes are only honoured in IDLE; DONE has busy low but is still off-limits.
    assign w_we    = r_busy ? (r_state == WRITE) : (bus.wr_en && r_state == IDLE);
    assign w_waddr = r_busy ? r_idx[AW-1:0] : bus.wr_addr;
    assign w_wdata = r_busy ? r_v - TH : bus.wr_data;
    assign w_raddr = r_busy ? r_idx[AW-1:0] : bus.rd_addr;
    assign w_ge    = (w_rdata >= TH);
    assign w_last  = (r_idx >= IW'(DEPTH - 1));

    stats_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_fold  <= 1'b0;
            r_v     <= '0;
            r_min   <= '1;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.go) begin
                        r_fold  <= bus.fold;
                        r_idx   <= '0;
                        r_min   <= '1;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: r_state <= EVAL;
                EVAL: begin
                    r_v <= w_rdata;
                    if (w_rdata < r_min) r_min <= w_rdata;
                    r_sum <= r_sum + SW'(w_rdata);
                    if (w_ge) r_cnt <= r_cnt + 1'b1;
                    if (r_fold && w_ge) begin
                        r_state <= WRITE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_state <= READ;
                        end
                    end
                end
                WRITE: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end else begin
                        r_state <= READ;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ARRAY_STATS_MAX_EN
    logic [DATA_W-1:0] r_max;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max <= '0;
        end else if (r_state == IDLE && bus.go) begin
            r_max <= '0;
        end else if (r_state == EVAL && w_rdata > r_max) begin
            r_max <= w_rdata;
        end
    end

    assign bus.max = r_max;
`else
    assign bus.max = '0;
`endif

    assign bus.rd_data  = w_rdata;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.min      = r_min;
    assign bus.sum      = r_sum;
    assign bus.count_ge = r_cnt;

endmodule

// File: tb/tb_array_stats_scan.sv
// Directed bench for array_stats_scan: hand-computed results, latencies and readback.
module tb_array_stats_scan;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int THRESH = 128;
    localparam int AW     = $clog2(DEPTH);
`ifdef ARRAY_STATS_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    array_stats_scan_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    array_stats_scan #(.DATA_W(DATA_W), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(a);
        bus.wr_data = DATA_W'(d);
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd(input int a, output int d);
        @(negedge clk);
        bus.rd_addr = AW'(a);
        @(negedge clk);
        d = int'(bus.rd_data);
    endtask

    // Starts a scan and counts edges from the go-sampling edge to the edge that raises done.
    // inj > 0 drives a stray go plus a host write to entry 15 for one cycle at that count.
    task automatic scan(input logic f, input int inj, output int lat);
        @(negedge clk);
        bus.go   = 1'b1;
        bus.fold = f;
        @(posedge clk);
        lat = 0;
        #1;
        bus.go = 1'b0;
        check("busy_start", 32'(bus.busy), 1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (inj > 0 && lat == inj) begin
                bus.go      = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_addr = AW'(15);
                bus.wr_data = DATA_W'(7);
            end else begin
                bus.go    = 1'b0;
                bus.wr_en = 1'b0;
            end
            if (bus.done) break;
        end
        bus.go    = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    initial begin
        int lat;
        int d;
        int acc;

        bus.go      = 1'b0;
        bus.fold    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_done",  32'(bus.done), 0);
        check("rst_min",   32'(bus.min), 255);
        check("rst_max",   32'(bus.max), 0);
        check("rst_sum",   32'(bus.sum), 0);
        check("rst_cnt",   32'(bus.count_ge), 0);
        check("rst_rdata", 32'(bus.rd_data), 0);
        rst_n = 1'b1;

        // Ramp 0..15, no fold
        for (int i = 0; i < DEPTH; i++) wr(i, i);
        scan(1'b0, 0, lat);
        check("s1_lat", 32'(lat), 33);
        check("s1_min", 32'(bus.min), 0);
        check("s1_max", 32'(bus.max), MAX_EN ? 32'd15 : 32'd0);
        check("s1_sum", 32'(bus.sum), 120);
        check("s1_cnt", 32'(bus.count_ge), 0);
        rd(7, d);
        check("s1_rd7", 32'(d), 7);

        // go held high: ignored in DONE, accepted in the following IDLE cycle
        @(negedge clk);
        bus.go = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
        check("b2b_lat1", 32'(lat), 33);
        check("b2b_busy_in_done", 32'(bus.busy), 0);
        @(posedge clk);
        lat++;
        #1;
        bus.go = 1'b0;
        check("b2b_busy_restart", 32'(bus.busy), 1);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.done) break;
        end
        check("b2b_lat2", 32'(lat), 67);
        check("b2b_sum", 32'(bus.sum), 120);

        // All 255, fold
        for (int i = 0; i < DEPTH; i++) wr(i, 255);
        scan(1'b1, 0, lat);
        check("s2_lat", 32'(lat), 49);
        check("s2_min", 32'(bus.min), 255);
        check("s2_max", 32'(bus.max), MAX_EN ? 32'd255 : 32'd0);
        check("s2_sum", 32'(bus.sum), 4080);
        check("s2_cnt", 32'(bus.count_ge), 16);
        for (int i = 0; i < DEPTH; i++) begin
            rd(i, d);
            check($sformatf("s2_rd%0d", i), 32'(d), 127);
        end

        // Alternating 128/127, fold; 128 folds to exactly 0
        for (int i = 0; i < DEPTH; i++) wr(i, (i % 2 == 0) ? 128 : 127);
        scan(1'b1, 0, lat);
        check("s3_lat", 32'(lat), 41);
        check("s3_min", 32'(bus.min), 127);
        check("s3_max", 32'(bus.max), MAX_EN ? 32'd128 : 32'd0);
        check("s3_sum", 32'(bus.sum), 2040);
        check("s3_cnt", 32'(bus.count_ge), 8);
        for (int i = 0; i < 4; i++) begin
            rd(i, d);
            check($sformatf("s3_rd%0d", i), 32'(d), (i % 2 == 0) ? 32'd0 : 32'd127);
        end

        // 0,10..150, fold, with a stray go and host write mid-scan
        for (int i = 0; i < DEPTH; i++) wr(i, i * 10);
        scan(1'b1, 5, lat);
        check("s4_lat", 32'(lat), 36);
        check("s4_min", 32'(bus.min), 0);
        check("s4_max", 32'(bus.max), MAX_EN ? 32'd150 : 32'd0);
        check("s4_sum", 32'(bus.sum), 1200);
        check("s4_cnt", 32'(bus.count_ge), 3);
        rd(15, d);
        check("s4_rd15", 32'(d), 22);
        rd(13, d);
        check("s4_rd13", 32'(d), 2);
        rd(12, d);
        check("s4_rd12", 32'(d), 120);

        // Reset mid-scan
        @(negedge clk);
        bus.go   = 1'b1;
        bus.fold = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("s5_busy", 32'(bus.busy), 0);
        check("s5_done", 32'(bus.done), 0);
        check("s5_min",  32'(bus.min), 255);
        check("s5_sum",  32'(bus.sum), 0);
        check("s5_cnt",  32'(bus.count_ge), 0);
        @(negedge clk);
        rst_n = 1'b1;
        acc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            rd(i, d);
            acc = acc | d;
        end
        check("s5_clear", 32'(acc), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
